// File: rtl/hps_cmd_serializer.sv
// Byte-wise serializer for the HPS write port: turns one render, pixel-load or
// clear command into chipselect/write/address/writedata beats.
`timescale 1ns/1ps

module hps_cmd_serializer #(
  parameter int GAP_CYCLES        = 0,
  parameter bit SKIP_REDUNDANT_OP = 1'b0
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_kind,
  input  logic [47:0] cmd_data,
  output logic        cmd_err,
  output logic        busy,
  output logic [7:0]  hps_writedata,
  output logic [2:0]  hps_address,
  output logic        hps_write,
  output logic        hps_chipselect,
  output logic [2:0]  fsm_state
);

  // Handshake: a command is taken on a posedge where cmd_valid && cmd_ready;
  // cmd_kind/cmd_data are captured on that edge and may change afterwards.
  typedef enum logic [2:0] {IDLE, OP, BODY, GAP, ERR} state_t;

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
  localparam logic [1:0] K_RENDER = 2'd0;
  localparam logic [1:0] K_PIXEL  = 2'd1;
  localparam logic [1:0] K_RSVD   = 2'd3;

  state_t        state_q, state_d;
  logic [1:0]    kind_q, kind_d;
  logic [47:0]   data_q, data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    last_op_q, last_op_d;
  logic          ready_d, err_d, busy_d, wr_d;
  logic [7:0]    wd_d;
  logic [2:0]    addr_d;
  logic          adv, reject, skip;
  logic [2:0]    first_addr, next_addr;

  // Pixel load: data[43:24] is the pixel address, data[23:0] the RGB value.
  function automatic logic [7:0] beat_byte(input logic [1:0] kind,
                                           input logic [47:0] d,
                                           input logic [2:0] a);
    logic [7:0] b;
    b = 8'h00;
    case (kind)
      K_RENDER: case (a)
        3'd0: b = d[47:40];
        3'd1: b = d[39:32];
        3'd2: b = d[31:24];
        3'd3: b = d[23:16];
        3'd4: b = d[15:8];
        3'd5: b = d[7:0];
        default: b = 8'h00;
      endcase
      K_PIXEL: case (a)
        3'd0: b = 8'hFD;
        3'd1: b = d[23:16];
        3'd2: b = d[15:8];
        3'd3: b = d[7:0];
        3'd4: b = {4'h0, d[43:40]};
        3'd5: b = d[39:32];
        3'd6: b = d[31:24];
        default: b = 8'h00;
      endcase
      default: b = (a == 3'd0) ? 8'hFE : 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] last_addr(input logic [1:0] kind);
    case (kind)
      K_RENDER: return 3'd5;
      K_PIXEL:  return 3'd6;
      default:  return 3'd1;
    endcase
  endfunction

  always_comb begin
    reject     = (cmd_kind == K_RSVD) ||
                 (cmd_kind == K_RENDER && (cmd_data[47:40] == 8'hFD || cmd_data[47:40] == 8'hFE));
    skip       = SKIP_REDUNDANT_OP && (cmd_kind == K_PIXEL) && (last_op_q == 8'hFD);
    first_addr = skip ? 3'd1 : 3'd0;
    next_addr  = hps_address + 3'd1;

    state_d   = state_q;
    kind_d    = kind_q;
    data_d    = data_q;
    gap_d     = gap_q;
    last_op_d = last_op_q;
    ready_d   = cmd_ready;
    err_d     = 1'b0;
    busy_d    = busy;
    wd_d      = hps_writedata;
    addr_d    = hps_address;
    wr_d      = 1'b0;
    adv       = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (cmd_valid && cmd_ready) begin
          kind_d  = cmd_kind;
          data_d  = cmd_data;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (reject) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            addr_d  = first_addr;
            wd_d    = beat_byte(cmd_kind, cmd_data, first_addr);
            wr_d    = 1'b1;
            state_d = skip ? BODY : OP;
            if (!skip) last_op_d = beat_byte(cmd_kind, cmd_data, 3'd0);
          end
        end
      end
      ERR: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      OP, BODY: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = GW'(1);
        end else begin
          adv = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) adv = 1'b1;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Leave the current beat (and its gap): either the next address or done.
    if (adv) begin
      if (hps_address == last_addr(kind_q)) begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end else begin
        addr_d  = next_addr;
        wd_d    = beat_byte(kind_q, data_q, next_addr);
        wr_d    = 1'b1;
        state_d = BODY;
      end
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      kind_q         <= 2'd0;
      data_q         <= 48'd0;
      gap_q          <= '0;
      last_op_q      <= 8'h00;
      cmd_ready      <= 1'b0;
      cmd_err        <= 1'b0;
      busy           <= 1'b0;
      hps_writedata  <= 8'h00;
      hps_address    <= 3'd0;
      hps_write      <= 1'b0;
      hps_chipselect <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      data_q         <= data_d;
      gap_q          <= gap_d;
      last_op_q      <= last_op_d;
      cmd_ready      <= ready_d;
      cmd_err        <= err_d;
      busy           <= busy_d;
      hps_writedata  <= wd_d;
      hps_address    <= addr_d;
      hps_write      <= wr_d;
      hps_chipselect <= wr_d;
    end
  end

  assign fsm_state = state_q;

endmodule
